// File: rtl/fetch_bundle_queue_if.sv
// fetch_bundle_queue_if: imem, redirect and issue-side signals of fetch_bundle_queue.
// FETCH_QUEUE_PERF_EN adds the perf counter outputs.
interface fetch_bundle_queue_if #(
   parameter int FETCH_WIDTH = 8,
   parameter int DEPTH       = 4
);
   localparam int CW = $clog2(FETCH_WIDTH+1);
   localparam int QW = $clog2(DEPTH+1);
   logic [31:0]                  o_imem_addr;
   logic [FETCH_WIDTH-1:0][31:0] i_imem_data;
   logic                         i_redirect_valid;
   logic [31:0]                  i_redirect_pc;
   logic                         o_out_valid;
   logic [31:0]                  o_out_pc;
   logic [FETCH_WIDTH-1:0][31:0] o_out_instr;
   logic [CW-1:0]                o_out_count;
   logic [CW-1:0]                i_consume_count;
   logic                         o_consume_error;
   logic [QW-1:0]                o_queue_count;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0]                  o_perf_full_cycles;
   logic [31:0]                  o_perf_flush_count;
   modport slave (
      output o_imem_addr, o_out_valid, o_out_pc, o_out_instr, o_out_count, o_consume_error, o_queue_count,
             o_perf_full_cycles, o_perf_flush_count,
      input  i_imem_data, i_redirect_valid, i_redirect_pc, i_consume_count
   );
   modport master (
      input  o_imem_addr, o_out_valid, o_out_pc, o_out_instr, o_out_count, o_consume_error, o_queue_count,
             o_perf_full_cycles, o_perf_flush_count,
      output i_imem_data, i_redirect_valid, i_redirect_pc, i_consume_count
   );
`else
   modport slave (
      output o_imem_addr, o_out_valid, o_out_pc, o_out_instr, o_out_count, o_consume_error, o_queue_count,
      input  i_imem_data, i_redirect_valid, i_redirect_pc, i_consume_count
   );
   modport master (
      input  o_imem_addr, o_out_valid, o_out_pc, o_out_instr, o_out_count, o_consume_error, o_queue_count,
      output i_imem_data, i_redirect_valid, i_redirect_pc, i_consume_count
   );
`endif
endinterface

// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: imem fetch buffer presenting bundles aligned at the oldest unconsumed instruction.
// FETCH_QUEUE_PERF_EN adds saturating full-stall and flush counters.
module fetch_bundle_queue #(
   parameter int          FETCH_WIDTH = 8,
   parameter int          DEPTH       = 4,
   parameter logic [31:0] START_PC    = 32'h0000_3000
) (
   input logic                 clk,
   input logic                 reset,
   fetch_bundle_queue_if.slave bus
);
   localparam int CW = $clog2(FETCH_WIDTH+1);
   localparam int QW = $clog2(DEPTH+1);
   localparam int OW = $clog2(FETCH_WIDTH);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t                       r_state, w_state_nxt;
   logic [31:0]                  r_fetch_pc, r_req_pc;
   logic                         r_pend, r_epoch, r_req_epoch, r_err;
   logic [AW-1:0]                r_wp, r_rp;
   logic [QW-1:0]                r_cnt;
   logic [OW-1:0]                r_off;
   logic [FETCH_WIDTH-1:0][31:0] r_data [DEPTH];
   logic [31:0]                  r_pc [DEPTH];
   logic                         w_redir, w_valid, w_room, w_issue, w_push, w_pop;
   logic [CW-1:0]                w_avail, w_eff, w_sum;
   assign w_redir = bus.i_redirect_valid;
   assign w_valid = r_cnt != '0;
   assign w_room  = (r_cnt + QW'(r_pend)) < QW'(DEPTH);
   assign w_avail = w_valid ? CW'(FETCH_WIDTH) - CW'(r_off) : '0;
   assign w_eff   = bus.i_consume_count > w_avail ? w_avail : bus.i_consume_count;
   assign w_sum   = CW'(r_off) + w_eff;
   assign w_pop   = w_valid && w_sum == CW'(FETCH_WIDTH);
   // responses issued before a redirect carry the old epoch and are dropped
   assign w_push  = r_pend && r_req_epoch == r_epoch;
   assign bus.o_imem_addr     = r_fetch_pc;
   assign bus.o_out_valid     = w_valid;
   assign bus.o_out_count     = w_avail;
   assign bus.o_out_pc        = w_valid ? r_pc[r_rp] + 32'({r_off, 2'b00}) : '0;
   assign bus.o_out_instr     = w_valid ? r_data[r_rp] >> {r_off, 5'd0} : '0;
   assign bus.o_consume_error = r_err;
   assign bus.o_queue_count   = r_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= RUN;
      else r_state <= w_state_nxt;
   always_comb begin
      w_state_nxt = w_redir ? FLUSH : RUN;
      w_issue = !w_redir && (r_state == FLUSH || w_room);
   end
   always_ff @(posedge clk)
      if (w_push) begin
         r_data[r_wp] <= bus.i_imem_data;
         r_pc[r_wp]   <= r_req_pc;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_fetch_pc  <= START_PC;
         r_req_pc    <= '0;
         r_pend      <= 1'b0;
         r_epoch     <= 1'b0;
         r_req_epoch <= 1'b0;
         r_err       <= 1'b0;
         r_wp        <= '0;
         r_rp        <= '0;
         r_cnt       <= '0;
         r_off       <= '0;
      end else if (w_redir) begin
         r_fetch_pc <= {bus.i_redirect_pc[31:2], 2'b00};
         r_pend     <= 1'b0;
         r_epoch    <= ~r_epoch;
         r_wp       <= '0;
         r_rp       <= '0;
         r_cnt      <= '0;
         r_off      <= '0;
      end else begin
         r_pend <= w_issue;
         if (w_issue) begin
            r_fetch_pc  <= r_fetch_pc + 32'(4*FETCH_WIDTH);
            r_req_pc    <= r_fetch_pc;
            r_req_epoch <= r_epoch;
         end
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) begin
            r_rp  <= r_rp + AW'(1);
            r_off <= '0;
         end else r_off <= OW'(w_sum);
         r_cnt <= r_cnt + QW'(w_push) - QW'(w_pop);
         if (bus.i_consume_count > w_avail) r_err <= 1'b1;
      end
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_full, r_flush;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_full  <= '0;
         r_flush <= '0;
      end else begin
         if (!w_redir && !w_issue && r_full != '1) r_full <= r_full + 32'd1;
         if (w_redir && r_flush != '1) r_flush <= r_flush + 32'd1;
      end
   assign bus.o_perf_full_cycles = r_full;
   assign bus.o_perf_flush_count = r_flush;
`endif
endmodule

// File: tb/tb_fetch_bundle_queue.sv
// tb_fetch_bundle_queue: scoreboard bench for fetch_bundle_queue with a 1-cycle-latency imem model.
module tb_fetch_bundle_queue;
   logic        clk = 1'b0;
   logic        reset;
   int          n_chk = 0;
   int          n_err = 0;
   int          b_off = 0;
   logic [31:0] exp_q [$];
   fetch_bundle_queue_if #(.FETCH_WIDTH(8), .DEPTH(4)) bus();
   fetch_bundle_queue #(.FETCH_WIDTH(8), .DEPTH(4), .START_PC(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction
   always @(posedge clk)
      for (int j = 0; j < 8; j++) bus.i_imem_data[j] <= f(bus.o_imem_addr + 32'(4*j));
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic restart(input logic [31:0] pc);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(pc + 32'(32*i));
      b_off = 0;
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   // compare the head view against the scoreboard, then consume c instructions
   task automatic cyc(input int c);
      int          eff;
      logic [31:0] pc;
      eff = 0;
      bus.i_consume_count = 4'(c);
      if (bus.o_out_valid && exp_q.size() > 0) begin
         pc = exp_q[0] + 32'(4*b_off);
         chk("sb_pc", bus.o_out_pc, pc);
         chk("sb_count", bus.o_out_count, 8-b_off);
         chk("sb_instr0", bus.o_out_instr[0], f(pc));
         chk("sb_instr_last", bus.o_out_instr[7-b_off], f(pc + 32'(4*(7-b_off))));
         if (b_off > 0) chk("sb_pad", bus.o_out_instr[7], 0);
         eff = c < 8-b_off ? c : 8-b_off;
      end
      tick();
      b_off += eff;
      if (b_off == 8) begin
         void'(exp_q.pop_front());
         b_off = 0;
      end
      bus.i_consume_count = '0;
   endtask
   initial begin
      reset = 1'b0;
      bus.i_redirect_valid = 1'b0;
      bus.i_redirect_pc = '0;
      bus.i_consume_count = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", bus.o_out_valid, 0);
      chk("rst_count", bus.o_out_count, 0);
      chk("rst_pc", bus.o_out_pc, 0);
      chk("rst_instr_zero", bus.o_out_instr == '0, 1);
      chk("rst_qc", bus.o_queue_count, 0);
      chk("rst_err", bus.o_consume_error, 0);
      chk("rst_addr", bus.o_imem_addr, 32'h3000);
      restart(32'h3000);
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         cyc(0);
         chk("fill_addr", bus.o_imem_addr, i <= 4 ? 32'h3000 + 32'(32*i) : 32'h3080);
         if (i == 1) chk("fill_valid_lat", bus.o_out_valid, 0);
         if (i == 2) begin
            chk("fill_valid", bus.o_out_valid, 1);
            chk("fill_pc", bus.o_out_pc, 32'h3000);
            chk("fill_count", bus.o_out_count, 8);
         end
         if (i >= 5) chk("full_qc", bus.o_queue_count, 4);
      end
      cyc(3);
      chk("part_pc", bus.o_out_pc, 32'h300C);
      chk("part_count", bus.o_out_count, 5);
      chk("part_instr0", bus.o_out_instr[0], f(32'h300C));
      cyc(5);
      chk("pop_pc", bus.o_out_pc, 32'h3020);
      chk("pop_count", bus.o_out_count, 8);
      chk("pop_qc", bus.o_queue_count, 3);
      cyc(0);
      cyc(0);
      chk("refill_qc", bus.o_queue_count, 4);
      for (int i = 0; i < 10; i++) begin
         cyc(8);
         if (i >= 2) chk("steady_qc", bus.o_queue_count, 2);
      end
      chk("steady_err", bus.o_consume_error, 0);
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc = 32'h2000;
      tick();
      bus.i_redirect_pc = 32'h3107;
      tick();
      bus.i_redirect_valid = 1'b0;
      chk("redir_qc", bus.o_queue_count, 0);
      chk("redir_valid", bus.o_out_valid, 0);
      chk("redir_addr", bus.o_imem_addr, 32'h3104);
      restart(32'h3104);
      cyc(2);
      chk("empty_err", bus.o_consume_error, 1);
      chk("empty_qc", bus.o_queue_count, 0);
      chk("empty_valid", bus.o_out_valid, 0);
      chk("flush_addr", bus.o_imem_addr, 32'h3124);
      cyc(0);
      chk("redir_ret_valid", bus.o_out_valid, 1);
      chk("redir_ret_pc", bus.o_out_pc, 32'h3104);
      chk("redir_ret_count", bus.o_out_count, 8);
      cyc(0);
      cyc(0);
      chk("mid_qc", bus.o_queue_count, 3);
      chk("sticky_err", bus.o_consume_error, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", bus.o_out_valid, 0);
      chk("arst_count", bus.o_out_count, 0);
      chk("arst_pc", bus.o_out_pc, 0);
      chk("arst_instr_zero", bus.o_out_instr == '0, 1);
      chk("arst_qc", bus.o_queue_count, 0);
      chk("arst_err", bus.o_consume_error, 0);
      chk("arst_addr", bus.o_imem_addr, 32'h3000);
      @(negedge clk);
      reset = 1'b0;
      restart(32'h3000);
      cyc(0);
      chk("restart_addr", bus.o_imem_addr, 32'h3020);
      cyc(0);
      chk("restart_valid", bus.o_out_valid, 1);
      chk("restart_pc", bus.o_out_pc, 32'h3000);
      for (int i = 0; i < 6; i++) cyc(i + 1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
